multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 168 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing plus a retired-instruction counter.
// Define MULTICYCLE_CONTROLLER_HALT_EN to make opcode 1111 stop the machine; otherwise it is an illegal opcode.
module multicycle_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memtoreg,
    output logic             pcsrc,
    output logic             alusrc,
    output logic             regdst,
    output logic             regwrite,
    output logic             jump,
    output logic [2:0]       alucontrol,
    output logic             pcen,
    output logic             irwrite,
    output logic             memwrite,
    output logic             mem_req,
    output logic [WIDTH-1:0] instr_count,
    output logic             halted,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             retire;

    logic [3:0] op;
    logic [2:0] funct;
    logic       is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, r_ok;
    logic       unused_instr_bits;

    assign op                = instr[15:12];
    assign funct             = instr[2:0];
    assign unused_instr_bits = ^instr;
    assign is_r              = (op == 4'b0000);
    assign is_addi           = (op == 4'b0001);
    assign is_lw             = (op == 4'b0010);
    assign is_sw             = (op == 4'b0011);
    assign is_beq            = (op == 4'b0100);
    assign is_j              = (op == 4'b0101);
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
    assign is_halt           = (op == 4'b1111);
`else
    assign is_halt           = 1'b0;
`endif
    // R-type funct codes above SLT have no ALU operation behind them.
    assign r_ok              = (funct <= 3'b100);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_r || is_addi || is_lw || is_sw || is_beq) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC: begin
                if ((is_r && r_ok) || is_addi) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_sw ? S_FETCH : S_WB;
                    retire  = is_sw;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        count_d = retire ? count_q + {{(WIDTH-1){1'b0}}, 1'b1} : count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Outputs are decoded from the current state; reset masks them so a pending request dies at once.
    always_comb begin
        memtoreg   = 1'b0;
        pcsrc      = 1'b0;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        jump       = 1'b0;
        alucontrol = 3'b000;
        pcen       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        mem_req    = 1'b0;
        halted     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    pcen    = mem_ready;
                    irwrite = mem_ready;
                end
                S_DECODE: begin
                    jump = is_j;
                    pcen = is_j;
                end
                S_EXEC: begin
                    if (is_r && r_ok) begin
                        alucontrol = funct;
                    end else if (is_addi || is_lw || is_sw) begin
                        alusrc = 1'b1;
                    end else if (is_beq) begin
                        alucontrol = 3'b001;
                        pcsrc      = zero;
                        pcen       = zero;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    memwrite = is_sw;
                    alusrc   = 1'b1;
                end
                S_WB: begin
                    regwrite = 1'b1;
                    regdst   = is_r;
                    memtoreg = is_lw;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign instr_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into an expected per-cycle output trace from its opcode rules.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [15:0] instr;
    logic        memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
    logic [2:0]  alucontrol;
    logic        pcen, irwrite, memwrite, mem_req, halted;
    logic [15:0] instr_count;
    logic [2:0]  state_dbg;

    multicycle_controller #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .memtoreg(memtoreg), .pcsrc(pcsrc), .alusrc(alusrc), .regdst(regdst),
        .regwrite(regwrite), .jump(jump), .alucontrol(alucontrol), .pcen(pcen),
        .irwrite(irwrite), .memwrite(memwrite), .mem_req(mem_req),
        .instr_count(instr_count), .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] O_HALT = 14'h2000, O_MREQ = 14'h1000, O_MW   = 14'h0800,
                            O_IRW  = 14'h0400, O_PCEN = 14'h0200, O_JMP  = 14'h0100,
                            O_RW   = 14'h0080, O_RDST = 14'h0040, O_ASRC = 14'h0020,
                            O_PCS  = 14'h0010, O_M2R  = 14'h0008;

    logic [13:0] act;
    assign act = {halted, mem_req, memwrite, irwrite, pcen, jump, regwrite, regdst,
                  alusrc, pcsrc, memtoreg, alucontrol};

    logic [13:0] exp_q[$];
    bit          rdy_q[$];
    logic [15:0] exp_count;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [13:0] e, input bit r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction; fw/mw are memory wait cycles.
    task automatic plan_instr(input logic [15:0] ins, input logic z, input int fw, input int mw);
        logic [3:0] op = ins[15:12];
        logic [2:0] fn = ins[2:0];
        for (int i = 0; i < fw; i++) push(O_MREQ, 1'b0);
        push(O_MREQ | O_PCEN | O_IRW, 1'b1);
        case (op)
            4'h0: begin
                push(14'h0, rnd());
                if (fn <= 3'd4) begin
                    push(14'(fn), rnd());
                    push(O_RW | O_RDST, rnd());
                end else begin
                    push(14'h0, rnd());
                end
            end
            4'h1: begin
                push(14'h0, rnd());
                push(O_ASRC, rnd());
                push(O_RW, rnd());
            end
            4'h2, 4'h3: begin
                push(14'h0, rnd());
                push(O_ASRC, rnd());
                for (int i = 0; i <= mw; i++)
                    push(O_MREQ | O_ASRC | ((op == 4'h3) ? O_MW : 14'h0), i == mw);
                if (op == 4'h2) push(O_RW | O_M2R, rnd());
            end
            4'h4: begin
                push(14'h0, rnd());
                push(14'h1 | (z ? (O_PCS | O_PCEN) : 14'h0), rnd());
            end
            4'h5: push(O_JMP | O_PCEN, rnd());
            default: push(14'h0, rnd());
        endcase
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        if (op != 4'hF) exp_count++;
`else
        exp_count++;
`endif
    endtask

    task automatic run_plan(input string tag);
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            @(negedge clk);
            check_eq(tag, act, exp_q.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input string tag, input logic [15:0] ins, input logic z,
                            input int fw, input int mw);
        instr = ins;
        zero  = z;
        plan_instr(ins, z, fw, mw);
        run_plan(tag);
        check_eq({tag, "_count"}, instr_count, exp_count);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #2;
        exp_count = 16'h0;
        check_eq("rst_outs", act, 14'h0);
        check_eq("rst_count", instr_count, exp_count);
        @(posedge clk);
        #1;
        check_eq("rst_hold_outs", act, 14'h0);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] op = 4'($urandom_range(0, 14));
        return {op, 12'($urandom)};
    endfunction

    initial begin
        reset = 1'b1;
        instr = 16'h0;
        zero  = 1'b0;
        mem_ready = 1'b1;
        exp_count = 16'h0;
        #1;
        do_reset();

        do_instr("add", 16'h0000, 1'b0, 0, 0);
        do_instr("lw", 16'h2000 | 16'($urandom_range(0, 4095)), rnd(), 1, 3);
        do_instr("beq_z1", 16'h4000, 1'b1, 0, 0);
        do_instr("beq_z0", 16'h4000, 1'b0, 2, 0);
        do_instr("sw", 16'h3000, rnd(), 0, 2);
        do_instr("r_bad_funct", 16'h0007, rnd(), 0, 0);
        do_instr("illegal", 16'h9000, rnd(), 0, 0);

        for (int i = 0; i < 80; i++)
            do_instr("rand", rand_instr(), rnd(), $urandom_range(0, 3), $urandom_range(0, 3));

        // Store abandoned by an asynchronous reset while waiting on memory.
        instr = 16'h3000 | 16'($urandom_range(0, 4095));
        zero  = rnd();
        push(O_MREQ | O_PCEN | O_IRW, 1'b1);
        push(14'h0, rnd());
        push(O_ASRC, rnd());
        push(O_MREQ | O_MW | O_ASRC, 1'b0);
        push(O_MREQ | O_MW | O_ASRC, 1'b0);
        run_plan("sw_pre_rst");
        #1;
        check_eq("sw_inflight", act, O_MREQ | O_MW | O_ASRC);
        do_reset();
        do_instr("post_rst", rand_instr(), rnd(), 1, 1);

        // Counter wrap: 65535 jumps from a clean reset.
        do_reset();
        instr     = 16'h5000;
        mem_ready = 1'b1;
        repeat (2 * 65535) @(posedge clk);
        #1;
        exp_count = 16'hFFFF;
        check_eq("count_ffff", instr_count, exp_count);
        do_instr("wrap", rand_instr(), rnd(), 0, 1);
        check_eq("wrap_zero", instr_count, 16'h0000);

        do_instr("halt_op", 16'hF000 | 16'($urandom_range(0, 4095)), rnd(), 1, 0);
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        repeat (6) push(O_HALT, rnd());
        run_plan("halted");
        check_eq("halt_count", instr_count, exp_count);
        do_reset();
        do_instr("after_halt", rand_instr(), rnd(), 0, 0);
`else
        do_instr("after_f000", rand_instr(), rnd(), 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
